spi_master: RTL and testbench

//  SPI initiator (mode 0, MSB first) that drives the serial link into our shift-register-based SPI peripheral.

---
 rtl/spi_master_if.sv | 39 +++
 rtl/spi_master.sv | 126 ++++++++++++
 tb/tb_spi_master.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
// spi_master_if
//   Bundles the host-side handshake and the SPI pin signals of spi_master.
//   master modport: the initiator's view (drives rxData/busy/done and the SPI
//   outputs sclk/cs/mosi; reads start/txData/miso).
//   slave modport: the view of whatever surrounds it (host logic plus the
//   peripheral pins).
// Ports (signals)
//   start   request a transfer (honoured only while idle)
//   txData  word to send, latched when start is accepted
//   rxData  last received word, updated together with done
//   busy    transfer in progress
//   done    one-cycle end-of-transfer pulse
//   sclk    serial clock, idle low
//   cs      chip select, active low
//   mosi    serial data out
//   miso    serial data in
interface spi_master_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] txData;
    logic [WIDTH-1:0] rxData;
    logic             busy;
    logic             done;
    logic             sclk;
    logic             cs;
    logic             mosi;
    logic             miso;

    modport master (
        input  start, txData, miso,
        output rxData, busy, done, sclk, cs, mosi
    );

    modport slave (
        output start, txData, miso,
        input  rxData, busy, done, sclk, cs, mosi
    );
endinterface

// File: rtl/spi_master.sv
// spi_master
//   SPI initiator, mode 0 (sclk idle low, data sampled on sclk rise, changed
//   on sclk fall), MSB first. Accepts a parallel word with a start strobe,
//   shifts it out on mosi while capturing miso into a parallel word.
//   Frame: LEAD (cs low, first bit presented) then WIDTH x (HIGH, LOW); the
//   last LOW is the trailing phase. Every phase lasts CLKDIV clk cycles, so
//   cs stays low for (2*WIDTH+1)*CLKDIV cycles.
// Parameters
//   WIDTH   bits per transfer (>=2)
//   CLKDIV  clk cycles per sclk half-period (>=1)
// Ports
//   clk     system clock, all logic on posedge
//   reset   asynchronous, active-high reset
//   bus     spi_master_if.master: start/txData in, rxData/busy/done out,
//           sclk/cs/mosi out, miso in
module spi_master #(
    parameter int WIDTH  = 8,
    parameter int CLKDIV = 4
) (
    input  logic          clk,
    input  logic          reset,
    spi_master_if.master  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LEAD = 2'd1;
    localparam logic [1:0] HIGH = 2'd2;
    localparam logic [1:0] LOW  = 2'd3;

    localparam int PW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(CLKDIV - 1);
    localparam logic [BW-1:0] BIT_ALL    = BW'(WIDTH);
    localparam logic [BW-1:0] BIT_PENULT = BW'(WIDTH - 1);

    logic [1:0]       stateReg;
    logic [PW-1:0]    phaseCnt;
    logic [BW-1:0]    bitCnt;
    logic [WIDTH-1:0] txShift;
    logic [WIDTH-1:0] rxShift;
    logic [WIDTH-1:0] rxDataReg;
    logic             doneReg;
    logic             sclkReg;
    logic             csReg;
    logic             mosiReg;
    logic             phaseEnd;

    assign phaseEnd = (phaseCnt == PHASE_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg  <= IDLE;
            phaseCnt  <= '0;
            bitCnt    <= '0;
            txShift   <= '0;
            rxShift   <= '0;
            rxDataReg <= '0;
            doneReg   <= 1'b0;
            sclkReg   <= 1'b0;
            csReg     <= 1'b1;
            mosiReg   <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (bus.start) begin
                        txShift  <= bus.txData;
                        bitCnt   <= '0;
                        phaseCnt <= '0;
                        csReg    <= 1'b0;
                        mosiReg  <= bus.txData[WIDTH-1];
                        stateReg <= LEAD;
                    end
                end
                LEAD: begin
                    if (phaseEnd) begin
                        phaseCnt <= '0;
                        sclkReg  <= 1'b1;
                        rxShift  <= {rxShift[WIDTH-2:0], bus.miso};
                        stateReg <= HIGH;
                    end else begin
                        phaseCnt <= phaseCnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (phaseEnd) begin
                        phaseCnt <= '0;
                        sclkReg  <= 1'b0;
                        txShift  <= {txShift[WIDTH-2:0], 1'b0};
                        bitCnt   <= bitCnt + 1'b1;
                        // After the final bit, mosi parks low for the trailing phase.
                        mosiReg  <= (bitCnt == BIT_PENULT) ? 1'b0 : txShift[WIDTH-2];
                        stateReg <= LOW;
                    end else begin
                        phaseCnt <= phaseCnt + 1'b1;
                    end
                end
                LOW: begin
                    if (phaseEnd) begin
                        phaseCnt <= '0;
                        if (bitCnt == BIT_ALL) begin
                            csReg     <= 1'b1;
                            rxDataReg <= rxShift;
                            doneReg   <= 1'b1;
                            stateReg  <= IDLE;
                        end else begin
                            sclkReg  <= 1'b1;
                            rxShift  <= {rxShift[WIDTH-2:0], bus.miso};
                            stateReg <= HIGH;
                        end
                    end else begin
                        phaseCnt <= phaseCnt + 1'b1;
                    end
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

    // busy is decoded from state so it drops in the same cycle done rises.
    assign bus.busy   = (stateReg != IDLE);
    assign bus.done   = doneReg;
    assign bus.rxData = rxDataReg;
    assign bus.sclk   = sclkReg;
    assign bus.cs     = csReg;
    assign bus.mosi   = mosiReg;
endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;
    logic clk = 1'b0;
    logic reset;
    int   misoModeA;   // 0: loopback, 1: tied high, 2: tied low
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    spi_master_if #(.WIDTH(8)) busA();
    spi_master_if #(.WIDTH(8)) busB();

    assign busA.miso = (misoModeA == 0) ? busA.mosi : (misoModeA == 1);
    assign busB.miso = busB.mosi;

    spi_master #(.WIDTH(8), .CLKDIV(4)) dutA (.clk(clk), .reset(reset), .bus(busA));
    spi_master #(.WIDTH(8), .CLKDIV(1)) dutB (.clk(clk), .reset(reset), .bus(busB));

    typedef struct {
        logic [7:0] tx;
        int         misoMode;
        logic [7:0] expMosi;
        logic [7:0] expRx;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // One transfer on dutA (CLKDIV=4). Start is pulsed for one cycle; at cycle
    // index injIdx (0 = first cs-low cycle) start/txData are overwritten.
    task automatic runA(input string tag, input logic [7:0] tx, input int mode,
                        input logic [7:0] expMosi, input logic [7:0] expRx,
                        input int injIdx, input logic [7:0] injTx, input logic injStart);
        int         csLow = 0;
        int         rises = 0;
        logic [7:0] bits = '0;
        logic       prevSclk = 1'b0;
        logic       busyOk = 1'b1;
        logic       doneSeen = 1'b0;
        logic       busyAtDone = 1'b1;
        logic       csAtDone = 1'b0;
        logic [7:0] rxAtDone = '0;
        misoModeA    = mode;
        busA.txData  = tx;
        busA.start   = 1'b1;
        @(negedge clk);
        busA.start = 1'b0;
        for (int idx = 0; idx < 300 && !doneSeen; idx++) begin
            if (idx == injIdx) begin
                busA.start  = injStart;
                busA.txData = injTx;
            end
            if (idx == injIdx + 1) busA.start = 1'b0;
            if (busA.done) begin
                doneSeen   = 1'b1;
                busyAtDone = busA.busy;
                csAtDone   = busA.cs;
                rxAtDone   = busA.rxData;
            end else begin
                if (!busA.cs) begin
                    csLow++;
                    if (!busA.busy) busyOk = 1'b0;
                end
                if (busA.sclk && !prevSclk) begin
                    rises++;
                    bits = {bits[6:0], busA.mosi};
                end
                prevSclk = busA.sclk;
                @(negedge clk);
            end
        end
        check({tag, " done seen"}, 32'(doneSeen), 32'd1);
        check({tag, " cs low cycles"}, csLow, 32'd68);
        check({tag, " sclk rises"}, rises, 32'd8);
        check({tag, " mosi bits"}, 32'(bits), 32'(expMosi));
        check({tag, " rxData"}, 32'(rxAtDone), 32'(expRx));
        check({tag, " busy at done"}, 32'(busyAtDone), 32'd0);
        check({tag, " cs at done"}, 32'(csAtDone), 32'd1);
        check({tag, " busy continuous"}, 32'(busyOk), 32'd1);
        @(negedge clk);
        check({tag, " done width"}, 32'(busA.done), 32'd0);
    endtask

    initial begin
        vec_t vecs[6];
        int   rises;
        logic prevSclk;
        int   runs;
        int   lowCnt;
        int   highCnt;

        vecs[0] = '{tx: 8'hA5, misoMode: 0, expMosi: 8'hA5, expRx: 8'hA5};
        vecs[1] = '{tx: 8'h00, misoMode: 1, expMosi: 8'h00, expRx: 8'hFF};
        vecs[2] = '{tx: 8'h3C, misoMode: 2, expMosi: 8'h3C, expRx: 8'h00};
        vecs[3] = '{tx: 8'hC3, misoMode: 1, expMosi: 8'hC3, expRx: 8'hFF};
        vecs[4] = '{tx: 8'h01, misoMode: 0, expMosi: 8'h01, expRx: 8'h01};
        vecs[5] = '{tx: 8'h80, misoMode: 0, expMosi: 8'h80, expRx: 8'h80};

        reset       = 1'b1;
        misoModeA   = 0;
        busA.start  = 1'b0;
        busA.txData = '0;
        busB.start  = 1'b0;
        busB.txData = '0;
        repeat (2) @(negedge clk);
        check("reset cs", 32'(busA.cs), 32'd1);
        check("reset sclk", 32'(busA.sclk), 32'd0);
        check("reset mosi", 32'(busA.mosi), 32'd0);
        check("reset busy", 32'(busA.busy), 32'd0);
        check("reset done", 32'(busA.done), 32'd0);
        check("reset rxData", 32'(busA.rxData), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            runA($sformatf("vec%0d", i), vecs[i].tx, vecs[i].misoMode,
                 vecs[i].expMosi, vecs[i].expRx, -10, 8'h00, 1'b0);
        end

        // Start re-pulsed mid-transfer with a different word: ignored.
        runA("ignore start", 8'hA5, 0, 8'hA5, 8'hA5, 26, 8'h3C, 1'b1);
        repeat (3) @(negedge clk);
        check("ignore start no restart", 32'(busA.cs), 32'd1);
        check("ignore start rxData held", 32'(busA.rxData), 32'hA5);

        // txData changes right after acceptance must not leak into the frame.
        runA("txData change", 8'h12, 0, 8'h12, 8'h12, 0, 8'hFF, 1'b0);

        // Asynchronous reset between clock edges after the 4th sclk rise.
        misoModeA   = 0;
        busA.txData = 8'hA5;
        busA.start  = 1'b1;
        @(negedge clk);
        busA.start = 1'b0;
        rises    = 0;
        prevSclk = 1'b0;
        for (int idx = 0; idx < 100 && rises < 4; idx++) begin
            if (busA.sclk && !prevSclk) rises++;
            prevSclk = busA.sclk;
            if (rises < 4) @(negedge clk);
        end
        check("abort reached rise 4", rises, 32'd4);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort cs", 32'(busA.cs), 32'd1);
        check("abort sclk", 32'(busA.sclk), 32'd0);
        check("abort busy", 32'(busA.busy), 32'd0);
        check("abort rxData", 32'(busA.rxData), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        runA("after abort", 8'hA5, 0, 8'hA5, 8'hA5, -10, 8'h00, 1'b0);

        // CLKDIV=1, start held high: three back-to-back loopback transfers.
        busB.txData = 8'h81;
        busB.start  = 1'b1;
        runs    = 0;
        lowCnt  = 0;
        highCnt = 0;
        for (int idx = 0; idx < 200 && runs < 3; idx++) begin
            @(negedge clk);
            if (!busB.cs) begin
                if (runs > 0 && lowCnt == 0)
                    check($sformatf("b2b gap before %0d", runs), 32'(highCnt >= 1), 32'd1);
                lowCnt++;
                highCnt = 0;
            end else begin
                highCnt++;
            end
            if (busB.done) begin
                check($sformatf("b2b cs low %0d", runs), lowCnt, 32'd17);
                check($sformatf("b2b rxData %0d", runs), 32'(busB.rxData), 32'h81);
                runs++;
                lowCnt = 0;
                if (runs == 3) busB.start = 1'b0;
            end
        end
        check("b2b transfers", runs, 32'd3);
        repeat (4) @(negedge clk);
        check("b2b stopped cs", 32'(busB.cs), 32'd1);
        check("b2b stopped busy", 32'(busB.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
